// File: rtl/cfi_alert_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfi_alert_ctrl                                             |
// | Description : Collects one-cycle CFI violation pulses from NR_SRC        |
// |               detectors, buffers one PC per detector, and offers them    |
// |               one at a time to the exception path via valid/ready,       |
// |               serving pending detectors in round-robin order.            |
// | Ports       : clk_i, rst_ni          clock / async active-low reset      |
// |               det_i, det_pc_i        detection pulses and their PCs      |
// |               cfg_en_i, cfg_mask_i   global enable, per-detector mask    |
// |               clear_i                clears counter and overflow status  |
// |               alert_valid_o/ready_i  alert handshake                     |
// |               alert_src_o, alert_pc_o presented alert contents           |
// |               pending_o              per-detector pending flags          |
// |               alert_cnt_o            saturating accepted-alert counter   |
// |               overflow_o             sticky lost-detection flag          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cfi_alert_ctrl #(
   parameter int NR_SRC = 4,
   parameter int CNT_W  = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NR_SRC-1:0]               det_i,
   input  logic [NR_SRC-1:0][63:0]         det_pc_i,
   input  logic                            cfg_en_i,
   input  logic [NR_SRC-1:0]               cfg_mask_i,
   input  logic                            clear_i,
   output logic                            alert_valid_o,
   input  logic                            alert_ready_i,
   output logic [$clog2(NR_SRC)-1:0]       alert_src_o,
   output logic [63:0]                     alert_pc_o,
   output logic [NR_SRC-1:0]               pending_o,
   output logic [CNT_W-1:0]                alert_cnt_o,
   output logic                            overflow_o
);

   localparam int SRC_W = $clog2(NR_SRC);
   localparam int SUM_W = SRC_W + 1;

   localparam logic [1:0] C_ST_IDLE     = 2'd0;
   localparam logic [1:0] C_ST_PRESENT  = 2'd1;
   localparam logic [1:0] C_ST_COOLDOWN = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [NR_SRC-1:0]       pending_q;
   logic [NR_SRC-1:0][63:0] pc_buf_q;
   logic [SRC_W-1:0]        src_q;
   logic [SRC_W-1:0]        rr_ptr_q;
   logic [63:0]             pc_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    ovf_q;

   logic                    w_hs;
   logic [NR_SRC-1:0]       w_capture;
   logic [NR_SRC-1:0]       w_consume;
   logic [NR_SRC-1:0]       w_lost;
   logic [NR_SRC-1:0]       w_pc_load;
   logic [NR_SRC-1:0]       w_pending_d;
   logic                    w_gnt_valid;
   logic [SRC_W-1:0]        w_gnt_idx;

   assign w_hs = alert_valid_o & alert_ready_i;

   // Per-detector capture logic. A capture into a pending slot that is not
   // being handed off this cycle is lost (old PC kept, overflow raised); a
   // capture on the slot being handed off replaces it cleanly.
   for (genvar k = 0; k < NR_SRC; k++) begin : g_src
      assign w_capture[k]   = det_i[k] & cfg_en_i & ~cfg_mask_i[k];
      assign w_consume[k]   = w_hs & (src_q == SRC_W'(k));
      assign w_lost[k]      = w_capture[k] & pending_q[k] & ~w_consume[k];
      assign w_pc_load[k]   = w_capture[k] & ~w_lost[k];
      assign w_pending_d[k] = w_capture[k] | (pending_q[k] & ~w_consume[k]);
   end

   // Round-robin arbiter: scan from rr_ptr_q upward with wrap. The loop runs
   // downward so the last hit (smallest offset from the pointer) wins.
   always_comb begin
      logic [SUM_W-1:0] sum;
      logic [SRC_W-1:0] cand;
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      sum         = '0;
      cand        = '0;
      for (int i = NR_SRC - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr_q} + SUM_W'(i);
         if (sum >= SUM_W'(NR_SRC)) begin
            sum = sum - SUM_W'(NR_SRC);
         end
         cand = sum[SRC_W-1:0];
         if (pending_q[cand]) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = cand;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= C_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         C_ST_IDLE:     if (w_gnt_valid) state_d = C_ST_PRESENT;
         C_ST_PRESENT:  if (alert_ready_i) state_d = C_ST_COOLDOWN;
         C_ST_COOLDOWN: state_d = C_ST_IDLE;
         default:       state_d = C_ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      alert_valid_o = (state_q == C_ST_PRESENT);
   end

   // Pending flags and per-detector PC buffers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
         pc_buf_q  <= '0;
      end else begin
         pending_q <= w_pending_d;
         for (int k = 0; k < NR_SRC; k++) begin
            if (w_pc_load[k]) begin
               pc_buf_q[k] <= det_pc_i[k];
            end
         end
      end
   end

   // Presented alert, round-robin pointer, counter and overflow status
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q    <= '0;
         pc_q     <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if ((state_q == C_ST_IDLE) && w_gnt_valid) begin
            src_q <= w_gnt_idx;
            pc_q  <= pc_buf_q[w_gnt_idx];
         end
         if (w_hs) begin
            rr_ptr_q <= (src_q == SRC_W'(NR_SRC - 1)) ? '0 : src_q + SRC_W'(1);
         end
         // clear_i takes priority over a same-cycle increment or overflow
         if (clear_i) begin
            cnt_q <= '0;
         end else if (w_hs && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (clear_i) begin
            ovf_q <= 1'b0;
         end else if (|w_lost) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign alert_src_o = src_q;
   assign alert_pc_o  = pc_q;
   assign pending_o   = pending_q;
   assign alert_cnt_o = cnt_q;
   assign overflow_o  = ovf_q;

endmodule
`default_nettype wire
